// File: rtl/svd_pkg.sv
// Shared definitions for the SVD-core datapath blocks: FSM encoding,
// pipeline depth limit and the select-width helper.
package svd_pkg;

   localparam int LAT_MAX = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int selw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One output-pipeline register for {data, valid, tag, last}. With ld_i low
// the payload holds while valid still shifts, so a bubble keeps the old word.
module mux_pipe_stage #(
   parameter int WIDTH = 24,
   parameter int SELW  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   input  logic [SELW-1:0]  tag_i,
   input  logic             last_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [SELW-1:0]  tag_o,
   output logic             last_o
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic [SELW-1:0]  tag_q;
   logic             last_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         tag_q   <= '0;
         last_q  <= 1'b0;
      end else if (ce_i) begin
         valid_q <= valid_i;
         if (ld_i) begin
            data_q <= data_i;
            tag_q  <= tag_i;
            last_q <= last_i;
         end
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign tag_o   = tag_q;
   assign last_o  = last_q;

endmodule

// File: rtl/mux_seq.sv
// N-channel registered selector feeding a shared datapath: manual select or
// a round-robin sweep of all channels launched by start, LAT-deep output.
module mux_seq
   import svd_pkg::*;
#(
   parameter  int WIDTH = 24,
   parameter  int NCH   = 4,
   parameter  int LAT   = 1,
   localparam int SELW  = selw(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_bus,
   input  logic [SELW-1:0]      sel,
   input  logic                 auto,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic                 ce,
   output logic [WIDTH-1:0]     out,
   output logic                 msb,
   output logic                 out_valid,
   output logic [SELW-1:0]      out_ch,
   output logic                 busy,
   output logic                 done
);

   if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
      $error("mux_seq: LAT out of range");
   end

   state_e          state_q, state_d;
   logic [SELW-1:0] cnt_q, cnt_d;
   logic            acc;
   logic [SELW-1:0] tag;
   logic            last;
   logic [WIDTH-1:0] word;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc     = ce & in_valid;
      tag     = sel;
      last    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // a start cycle's own word is still a manual sample
            if (ce && start && auto) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            tag  = cnt_q;
            last = (cnt_q == SELW'(NCH - 1));
            if (acc) begin
               if (last) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // out-of-range tags select nothing and yield a zero word
   always_comb begin
      word = '0;
      for (int k = 0; k < NCH; k++) begin
         if (tag == SELW'(k)) word = in_bus[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   logic [LAT:0][WIDTH-1:0] data_pipe;
   logic [LAT:0][SELW-1:0]  tag_pipe;
   logic [LAT:0]            vld_pipe;
   logic [LAT:0]            last_pipe;

   assign data_pipe[0] = word;
   assign tag_pipe[0]  = tag;
   assign vld_pipe[0]  = acc;
   assign last_pipe[0] = last;

   for (genvar i = 1; i <= LAT; i++) begin : g_stage
      mux_pipe_stage #(
         .WIDTH (WIDTH),
         .SELW  (SELW)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .ce_i    (ce),
         .ld_i    ((i == 1) ? acc : 1'b1),
         .data_i  (data_pipe[i-1]),
         .valid_i (vld_pipe[i-1]),
         .tag_i   (tag_pipe[i-1]),
         .last_i  (last_pipe[i-1]),
         .data_o  (data_pipe[i]),
         .valid_o (vld_pipe[i]),
         .tag_o   (tag_pipe[i]),
         .last_o  (last_pipe[i])
      );
   end

   assign out       = data_pipe[LAT];
   assign msb       = out[WIDTH-1];
   assign out_valid = vld_pipe[LAT];
   assign out_ch    = tag_pipe[LAT];
   assign done      = vld_pipe[LAT] & last_pipe[LAT];
   assign busy      = (state_q == ST_RUN);

endmodule
